vga_mem_arbiter: RTL and testbench
==================================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16: memory word address width.
REQ-002 The block SHALL have parameter DATA_W, default 8: memory word (pixel) width.
REQ-003 The block SHALL have port clk_pix, input, 1: pixel clock, the only clock.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port fetch_req, input, 1: display read request, no back-pressure.
REQ-006 The block SHALL have port fetch_addr, input, ADDR_W: display read address.
REQ-007 The block SHALL have ports fetch_valid (output, 1) and fetch_data (output, DATA_W): returned display pixel.
REQ-008 The block SHALL have ports host_valid (input, 1), host_we (input, 1), host_addr (input, ADDR_W) and host_wdata (input, DATA_W): host request.
REQ-009 The block SHALL have port host_ready, output, 1: host request accepted this cycle.
REQ-010 The block SHALL have ports host_rvalid (output, 1) and host_rdata (output, DATA_W): returned host read data.
REQ-011 The block SHALL have ports mem_en, mem_we, mem_addr and mem_wdata (outputs, widths 1, 1, ADDR_W, DATA_W): single-port synchronous memory request.
REQ-012 The block SHALL have port mem_rdata, input, DATA_W: memory read data, one cycle after a read with mem_en=1 and mem_we=0.
REQ-013 The block SHALL have port host_stall_cnt, output, 16: host stall statistic.

Function
REQ-014 host_ready SHALL be combinational and equal ~fetch_req: display has absolute priority.
REQ-015 A fetch SHALL be accepted whenever fetch_req=1; a host request SHALL be accepted when host_valid=1 and host_ready=1.
REQ-016 Accepted requests SHALL be registered onto mem_* on the next edge; with no acceptance, mem_en=0 and mem_we=0.
REQ-017 Each accepted read SHALL push a tag (NONE, FETCH or HOST) into a 2-stage tag pipeline aligned with the memory latency.
REQ-018 fetch_valid SHALL assert exactly 2 cycles after fetch acceptance, with fetch_data = mem_rdata registered.
REQ-019 host_rvalid SHALL assert exactly 2 cycles after host read acceptance.
REQ-020 Host writes (host_we=1) SHALL produce no host_rvalid.
REQ-021 Throughput SHALL be one request per cycle; back-to-back mixed tags SHALL return in order without loss.
REQ-022 fetch_data and host_rdata SHALL hold their last value when their valid is low.
REQ-023 With fetch_req held high continuously, the host SHALL be starved indefinitely (no fairness).

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately clear mem_en, mem_we, fetch_valid, host_rvalid, the tag pipeline, fetch_data, host_rdata, mem_addr, mem_wdata and host_stall_cnt to 0.
REQ-025 Reads in flight at reset SHALL be discarded; no valid pulse SHALL follow deassertion.
REQ-026 Reset deassertion SHALL be synchronised externally; the first request is accepted on the first edge with rst_n=1.

Configuration
REQ-027 With macro VGA_ARB_STALL_STATS_EN defined, host_stall_cnt SHALL increment each cycle host_valid=1 and host_ready=0, saturating at 16'hFFFF.
REQ-028 Without VGA_ARB_STALL_STATS_EN, host_stall_cnt SHALL be constant 0 and no counter logic SHALL be present.

Structure
REQ-029 Package vga_pkg SHALL hold the ADDR_W/DATA_W defaults and the tag enumeration TAG_NONE/TAG_FETCH/TAG_HOST.
REQ-030 The saturating counter SHALL be sub-module vga_sat_counter, instantiated only under the macro.

Verification
REQ-031 After reset, fetch_req=1 with addr 0x0010 on one cycle (mem holds 0xA5) -> mem_en=1 next cycle, fetch_valid=1 with 0xA5 two cycles after request.
REQ-032 fetch_req and host_valid both high for one cycle -> host_ready=0, fetch served; host retried next cycle with ready=1.
REQ-033 Host write 0x3C to 0x0100, then host read of 0x0100 -> no rvalid for the write; host_rvalid=1 with 0x3C two cycles after the read.
REQ-034 Alternating fetch/host reads every cycle for 8 cycles -> 4 fetch_valid and 4 host_rvalid pulses, in order, correct data.
REQ-035 rst_n pulsed low one cycle after a fetch -> no fetch_valid; all outputs 0 during reset.
REQ-036 With macro, host_valid=1 against fetch_req=1 for 70000 cycles -> host_stall_cnt=16'hFFFF; without macro it stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA memory arbiter:
//   - default memory address / data widths
//   - width of the host stall statistic
//   - read-return tag carried alongside each memory access
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 8;
    localparam int STALL_CNT_W    = 16;

    // Identifies who owns the read data coming back from memory.
    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_HOST  = 2'd2
    } tag_e;

endpackage : vga_pkg

// File: rtl/vga_sat_counter.sv
// ---------------------------------------------------------------------------
// vga_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//   clk_pix  in   clock
//   rst_n    in   asynchronous active-low reset, clears count to 0
//   inc      in   add one this cycle (ignored once saturated)
//   count    out  current count value
// ---------------------------------------------------------------------------
module vga_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : vga_sat_counter

// File: rtl/vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vga_mem_arbiter
// Shares one single-port synchronous memory between the display fetch path
// and a host port. The display always wins; the host is served only in
// cycles without a fetch and is never guaranteed progress.
//
// Every accepted request is registered onto mem_* on the next edge. Reads
// carry a tag through a two-stage pipeline matching the one-cycle memory
// latency, so returns come back exactly two cycles after acceptance and in
// request order.
//
// Ports:
//   clk_pix          in   pixel clock (only clock)
//   rst_n            in   asynchronous active-low reset
//   fetch_req/addr   in   display read request, no back-pressure
//   fetch_valid/data out  display read return (data holds while valid low)
//   host_valid/we/addr/wdata in  host request
//   host_ready       out  combinational, = ~fetch_req
//   host_rvalid/rdata out host read return (data holds while valid low)
//   mem_en/we/addr/wdata out  memory request
//   mem_rdata        in   memory read data, one cycle after a read
//   host_stall_cnt   out  host stall statistic
//
// Build option:
//   VGA_ARB_STALL_STATS_EN  when defined, host_stall_cnt counts cycles with
//                           host_valid=1 and host_ready=0 (saturating);
//                           otherwise it is tied to 0.
// ---------------------------------------------------------------------------
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                   clk_pix,
    input  logic                   rst_n,

    input  logic                   fetch_req,
    input  logic [ADDR_W-1:0]      fetch_addr,
    output logic                   fetch_valid,
    output logic [DATA_W-1:0]      fetch_data,

    input  logic                   host_valid,
    input  logic                   host_we,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [DATA_W-1:0]      host_wdata,
    output logic                   host_ready,
    output logic                   host_rvalid,
    output logic [DATA_W-1:0]      host_rdata,

    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,

    output logic [STALL_CNT_W-1:0] host_stall_cnt
);

    logic              host_acc;

    logic              mem_en_d,    mem_en_q;
    logic              mem_we_d,    mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d,  mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;

    // Stage 0 lines up with the request on mem_*, stage 1 with mem_rdata.
    tag_e              tag_s0_d, tag_s0_q;
    tag_e              tag_s1_d, tag_s1_q;

    logic [DATA_W-1:0] fetch_data_d, fetch_data_q;
    logic [DATA_W-1:0] host_rdata_d, host_rdata_q;

    // ------------------------------------------------------------------
    // Arbitration: the display has absolute priority.
    // ------------------------------------------------------------------
    assign host_ready = ~fetch_req;
    assign host_acc   = host_valid & ~fetch_req;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_s0_d    = TAG_NONE;

        if (fetch_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = fetch_addr;
            tag_s0_d   = TAG_FETCH;
        end else if (host_acc) begin
            mem_en_d   = 1'b1;
            mem_we_d   = host_we;
            mem_addr_d = host_addr;
            if (host_we) begin
                mem_wdata_d = host_wdata;
            end else begin
                // Writes return nothing, so only reads occupy a tag slot.
                tag_s0_d = TAG_HOST;
            end
        end
    end

    assign tag_s1_d = tag_s0_q;

    // ------------------------------------------------------------------
    // Read return. The memory already registers its output, so the data
    // ports pass mem_rdata straight through in the valid cycle and a
    // holding register keeps the last value afterwards.
    // ------------------------------------------------------------------
    assign fetch_valid = (tag_s1_q == TAG_FETCH);
    assign host_rvalid = (tag_s1_q == TAG_HOST);

    always_comb begin
        fetch_data_d = fetch_data_q;
        host_rdata_d = host_rdata_q;
        if (fetch_valid) begin
            fetch_data_d = mem_rdata;
        end
        if (host_rvalid) begin
            host_rdata_d = mem_rdata;
        end
    end

    assign fetch_data = fetch_data_d;
    assign host_rdata = host_rdata_d;

    // ------------------------------------------------------------------
    // State. Clearing the tag stages on reset is what discards reads that
    // were in flight when reset arrived.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag_s0_q     <= TAG_NONE;
            tag_s1_q     <= TAG_NONE;
            fetch_data_q <= '0;
            host_rdata_q <= '0;
        end else begin
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tag_s0_q     <= tag_s0_d;
            tag_s1_q     <= tag_s1_d;
            fetch_data_q <= fetch_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // ------------------------------------------------------------------
    // Host stall statistic.
    // ------------------------------------------------------------------
`ifdef VGA_ARB_STALL_STATS_EN
    vga_sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .inc     (host_valid & ~host_ready),
        .count   (host_stall_cnt)
    );
`else
    assign host_stall_cnt = '0;
`endif

endmodule : vga_mem_arbiter

// File: tb/tb_vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_mem_arbiter
// Self-checking bench for vga_mem_arbiter with a behavioural synchronous
// memory. Expected read returns are pushed to a scoreboard when requests are
// driven and compared when the DUT returns data.
// ---------------------------------------------------------------------------
module tb_vga_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

`ifdef VGA_ARB_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk_pix;
    logic          rst_n;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          host_valid;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   host_stall_cnt;

    vga_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk_pix        (clk_pix),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .host_valid     (host_valid),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ready     (host_ready),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .host_stall_cnt (host_stall_cnt)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    // Behavioural single-port memory driven by the DUT, plus an independent
    // reference copy maintained from the stimulus.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk_pix) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    typedef struct {
        bit            is_host;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] last_fetch = '0;
    logic [DW-1:0] last_host  = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Return monitor: in every cycle either the scoreboard head is due and
    // must appear, or no valid may be raised.
    always @(negedge clk_pix) begin : monitor
        exp_t e;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.is_host) begin
                check("host_ret_valids", {fetch_valid, host_rvalid}, 2'b01);
                check("host_rdata", host_rdata, e.data);
                last_host = e.data;
            end else begin
                check("fetch_ret_valids", {fetch_valid, host_rvalid}, 2'b10);
                check("fetch_data", fetch_data, e.data);
                last_fetch = e.data;
            end
        end else begin
            check("no_valid", {fetch_valid, host_rvalid}, 2'b00);
        end
    end

    // One request cycle. Expected acceptance follows the priority rule:
    // fetch always, host only when no fetch.
    task automatic drive(input logic f, input logic [AW-1:0] fa,
                         input logic hv, input logic hwe,
                         input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        exp_t e;
        @(posedge clk_pix);
        #1;
        fetch_req  = f;
        fetch_addr = fa;
        host_valid = hv;
        host_we    = hwe;
        host_addr  = ha;
        host_wdata = hd;
        if (f) begin
            e.is_host = 1'b0;
            e.data    = ref_mem[fa];
            e.due     = cyc + 2;
            sb.push_back(e);
        end else if (hv) begin
            if (hwe) begin
                ref_mem[ha] = hd;
            end else begin
                e.is_host = 1'b1;
                e.data    = ref_mem[ha];
                e.due     = cyc + 2;
                sb.push_back(e);
            end
        end
        #1;
        check("host_ready", host_ready, !f);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        mem_rdata  = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[16'h0010]     = 8'hA5;
        ref_mem[16'h0010] = 8'hA5;

        repeat (3) @(posedge clk_pix);
        #1;
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_fetch_data", fetch_data, 8'h00);
        rst_n = 1'b1;

        // Single fetch: request on mem_* next cycle, return two cycles later.
        drive(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
        idle();
        check("fetch_mem_en", mem_en, 1'b1);
        check("fetch_mem_we", mem_we, 1'b0);
        check("fetch_mem_addr", mem_addr, 16'h0010);
        idle();
        idle();
        check("fetch_hold_a5", fetch_data, 8'hA5);
        check("idle_mem_en", mem_en, 1'b0);

        // Collision: fetch wins, host retries next cycle and is accepted.
        drive(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0044, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 16'h0044, '0);
        check("retry_mem_addr_fetch", mem_addr, 16'h0020);
        idle();
        check("retry_mem_addr_host", mem_addr, 16'h0044);
        idle();
        idle();
        check("stall_cnt_one", host_stall_cnt, STATS ? 16'd1 : 16'd0);

        // Host write then read back the same address.
        drive(1'b0, '0, 1'b1, 1'b1, 16'h0100, 8'h3C);
        drive(1'b0, '0, 1'b1, 1'b0, 16'h0100, '0);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_wdata", mem_wdata, 8'h3C);
        check("wr_mem_addr", mem_addr, 16'h0100);
        idle();
        idle();
        idle();
        check("host_hold", host_rdata, last_host);
        check("host_hold_3c", host_rdata, 8'h3C);
        check("fetch_hold", fetch_data, last_fetch);

        // Alternating fetch / host reads every cycle.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1'b1, AW'(16'h0200 + i), 1'b0, 1'b0, '0, '0);
            else            drive(1'b0, '0, 1'b1, 1'b0, AW'(16'h0300 + i), '0);
        end
        repeat (3) idle();

        // Reset pulse one cycle after a fetch: the read must vanish.
        @(posedge clk_pix);
        #1;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0030;
        @(posedge clk_pix);
        #1;
        rst_n = 1'b0;
        #1;
        check("rr_mem_en", mem_en, 1'b0);
        check("rr_mem_we", mem_we, 1'b0);
        check("rr_mem_addr", mem_addr, 16'h0000);
        check("rr_mem_wdata", mem_wdata, 8'h00);
        check("rr_fetch_valid", fetch_valid, 1'b0);
        check("rr_host_rvalid", host_rvalid, 1'b0);
        check("rr_fetch_data", fetch_data, 8'h00);
        check("rr_host_rdata", host_rdata, 8'h00);
        check("rr_stall_cnt", host_stall_cnt, 16'h0000);
        @(posedge clk_pix);
        #2;
        check("rr_mem_en_held", mem_en, 1'b0);
        fetch_req = 1'b0;
        rst_n     = 1'b1;
        idle();
        idle();
        // First request after release is accepted on the first edge.
        drive(1'b0, '0, 1'b1, 1'b0, 16'h0055, '0);
        idle();
        check("post_rst_mem_en", mem_en, 1'b1);
        check("post_rst_mem_addr", mem_addr, 16'h0055);
        repeat (3) idle();

        // Host starved by a continuous fetch stream.
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, AW'(i), 1'b1, 1'b0, 16'h0400, '0);
        end
        repeat (3) idle();
        check("stall_cnt_sat", host_stall_cnt, STATS ? 16'hFFFF : 16'h0000);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_vga_mem_arbiter
